// File: rtl/b_format_decoder_pkg.sv
// Shared decode constants: functional-unit codes, format masks, B-form opcodes and body layout.
package b_format_decoder_pkg;

  localparam int FU_FX     = 0;
  localparam int FU_FP     = 1;
  localparam int FU_VX     = 2;
  localparam int FU_CR     = 3;
  localparam int FU_LS     = 4;
  localparam int FU_BRANCH = 6;

  localparam int FORMAT_W = 26;
  localparam int FMT_B    = 2;

  localparam int          PRIM_OPCODE_BC = 16;
  localparam logic [11:0] DEC_OPCODE_BC  = 12'h010;

  // Body is {BO, BI, BD, AA, LK, pad}, most significant field first.
  localparam int BO_W       = 5;
  localparam int BI_W       = 5;
  localparam int BD_W       = 14;
  localparam int BODY_PAD_W = 2;
  localparam int BODY_W     = BO_W + BI_W + BD_W + 2 + BODY_PAD_W;

endpackage

// File: rtl/b_format_decoder_b_form_fields.sv
// Combinational B-form field extractor: BO, BI, BD, AA and LK from a raw instruction word.
module b_form_fields #(
  parameter int instructionWidth = 32,
  parameter int regSize          = 5,
  parameter int immediateSize    = 14
) (
  input  logic [instructionWidth-1:0] instruction,
  output logic [regSize-1:0]          bo,
  output logic [regSize-1:0]          bi,
  output logic [immediateSize-1:0]    bd,
  output logic                        aa,
  output logic                        lk
);

  localparam int BD_LO = 2;
  localparam int BI_LO = BD_LO + immediateSize;
  localparam int BO_LO = BI_LO + regSize;
  localparam int OP_LO = BO_LO + regSize;

  // MSB-0 fields map onto LSB-0 indices counted down from the top of the word.
  assign lk = instruction[0];
  assign aa = instruction[1];
  assign bd = instruction[BI_LO-1:BD_LO];
  assign bi = instruction[BO_LO-1:BI_LO];
  assign bo = instruction[OP_LO-1:BO_LO];

  // Primary opcode bits arrive separately as instructionOpcode_i.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instruction[instructionWidth-1:OP_LO];

endmodule

// File: rtl/b_format_decoder.sv
// Single-register B-form decode stage (bc/bca/bcl/bcla); define B_FORMAT_DECODE_DEBUG_EN
// to print every accepted instruction in simulation.
module b_format_decoder
  import b_format_decoder_pkg::*;
#(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int instMinIdWidth          = 7,
  parameter int opcodeSize              = 12,
  parameter int PrimOpcodeSize          = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = FU_BRANCH,
  parameter int B                       = FMT_B,
  parameter int BDecoderInstance        = 0
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic                               stall_i,
  input  logic [FORMAT_W-1:0]                instFormat_i,
  input  logic [PrimOpcodeSize-1:0]          instructionOpcode_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic [instructionCounterWidth-1:0] instructionMajId_i,
  output logic                               enable_o,
  output logic [opcodeSize-1:0]              opcode_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic [funcUnitCodeSize-1:0]        functionalUnitType_o,
  output logic [instructionCounterWidth-1:0] instMajId_o,
  output logic [instMinIdWidth-1:0]          instMinId_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instPid_o,
  output logic [TidSize-1:0]                 instTid_o,
  output logic [BODY_W-1:0]                  instructionBody_o
);

  localparam logic [FORMAT_W-1:0] B_MASK = FORMAT_W'(B);

  logic [regSize-1:0]       bo;
  logic [regSize-1:0]       bi;
  logic [immediateSize-1:0] bd;
  logic                     aa;
  logic                     lk;
  logic                     accept;

  b_form_fields #(
    .instructionWidth(instructionWidth),
    .regSize         (regSize),
    .immediateSize   (immediateSize)
  ) u_fields (
    .instruction(instruction_i),
    .bo         (bo),
    .bi         (bi),
    .bd         (bd),
    .aa         (aa),
    .lk         (lk)
  );

  assign accept = enable_i && ((instFormat_i & B_MASK) != '0) &&
                  (instructionOpcode_i == PrimOpcodeSize'(PRIM_OPCODE_BC));

  // Reset beats stall beats capture; data fields only move on an accept.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      enable_o             <= 1'b0;
      opcode_o             <= '0;
      instructionOpcode_o  <= '0;
      instructionAddress_o <= '0;
      functionalUnitType_o <= '0;
      instMajId_o          <= '0;
      instMinId_o          <= '0;
      is64Bit_o            <= 1'b0;
      instPid_o            <= '0;
      instTid_o            <= '0;
      instructionBody_o    <= '0;
    end else if (!stall_i) begin
      enable_o <= accept;
      if (accept) begin
        opcode_o             <= opcodeSize'(DEC_OPCODE_BC);
        instructionOpcode_o  <= instructionOpcode_i;
        instructionAddress_o <= instructionAddress_i;
        functionalUnitType_o <= funcUnitCodeSize'(BranchUnitID);
        instMajId_o          <= instructionMajId_i;
        instMinId_o          <= '0;
        is64Bit_o            <= is64Bit_i;
        instPid_o            <= instructionPid_i;
        instTid_o            <= instructionTid_i;
        instructionBody_o    <= {bo, bi, bd, aa, lk, {BODY_PAD_W{1'b0}}};
      end
    end
  end

`ifdef B_FORMAT_DECODE_DEBUG_EN
  always @(posedge clock_i) begin
    if (reset_i && !stall_i && accept)
      $display("b_decoder[%0d] maj=%0d addr=%h BO=%b BI=%b BD=%h AA=%b LK=%b",
               BDecoderInstance, instructionMajId_i, instructionAddress_i, bo, bi, bd, aa, lk);
  end
`else
  logic unused_instance_tag;
  assign unused_instance_tag = ^32'(BDecoderInstance);
`endif

endmodule

// File: tb/tb_b_format_decoder.sv
// Directed self-checking bench for b_format_decoder with hand-computed expected packets.
module tb_b_format_decoder;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        stall;
  logic [25:0] fmt;
  logic [5:0]  prim_op;
  logic [31:0] instr;
  logic [63:0] addr;
  logic        is64;
  logic [19:0] pid;
  logic [15:0] tid;
  logic [63:0] maj;

  logic        v_o;
  logic [11:0] opc_o;
  logic [5:0]  prim_o;
  logic [63:0] addr_o;
  logic [2:0]  fu_o;
  logic [63:0] maj_o;
  logic [6:0]  min_o;
  logic        is64_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;
  logic [27:0] body_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Instruction A: BO=01110 BI=10001 BD=0x03FC AA=0 LK=1
  localparam logic [31:0] INSTR_A = 32'h41D1_0FF1;
  localparam logic [27:0] BODY_A  = 28'h7443FC4;
  // Instruction B: BO=10100 BI=00011 BD=0x2001 AA=1 LK=0, and C with AA=0 LK=1
  localparam logic [31:0] INSTR_B = 32'h4283_8006;
  localparam logic [27:0] BODY_B  = 28'hA0E0018;
  localparam logic [31:0] INSTR_C = 32'h4283_8005;
  localparam logic [27:0] BODY_C  = 28'hA0E0014;

  b_format_decoder dut (
    .clock_i             (clk),
    .reset_i             (rst_n),
    .enable_i            (enable),
    .stall_i             (stall),
    .instFormat_i        (fmt),
    .instructionOpcode_i (prim_op),
    .instruction_i       (instr),
    .instructionAddress_i(addr),
    .is64Bit_i           (is64),
    .instructionPid_i    (pid),
    .instructionTid_i    (tid),
    .instructionMajId_i  (maj),
    .enable_o            (v_o),
    .opcode_o            (opc_o),
    .instructionOpcode_o (prim_o),
    .instructionAddress_o(addr_o),
    .functionalUnitType_o(fu_o),
    .instMajId_o         (maj_o),
    .instMinId_o         (min_o),
    .is64Bit_o           (is64_o),
    .instPid_o           (pid_o),
    .instTid_o           (tid_o),
    .instructionBody_o   (body_o)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [25:0] f, input logic [5:0] op,
                       input logic [31:0] ins, input logic [63:0] a, input logic [63:0] m);
    enable  = en;
    fmt     = f;
    prim_op = op;
    instr   = ins;
    addr    = a;
    maj     = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 26'd2, 6'd16, INSTR_A, 64'd16, 64'd16);
    tick();
    tick();
    n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable got=%b exp=0", v_o); end
    n_cmp++; if (body_o !== 28'd0) begin n_fail++; $display("FAIL reset_body got=%h exp=0", body_o); end
    n_cmp++; if ({opc_o, prim_o, addr_o, fu_o, maj_o, min_o, is64_o, pid_o, tid_o} !== '0) begin
      n_fail++; $display("FAIL reset_data got opc=%h fu=%0d addr=%h maj=%h exp all zero", opc_o, fu_o, addr_o, maj_o);
    end
    rst_n = 1'b1;
    drive(1'b0, 26'd0, 6'd0, 32'd0, 64'd0, 64'd0);
    tick();
  endtask

  task automatic test_accept();
    is64 = 1'b1; pid = 20'hABCDE; tid = 16'h1234;
    drive(1'b1, 26'd2, 6'd16, INSTR_A, 64'd16, 64'd16);
    tick();
    drive(1'b0, 26'd2, 6'd16, INSTR_A, 64'd16, 64'd16);
    n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL accept_enable got=%b exp=1", v_o); end
    n_cmp++; if (opc_o !== 12'h010) begin n_fail++; $display("FAIL accept_opcode got=%h exp=010", opc_o); end
    n_cmp++; if (fu_o !== 3'd6) begin n_fail++; $display("FAIL accept_fu got=%0d exp=6", fu_o); end
    n_cmp++; if (body_o !== BODY_A) begin n_fail++; $display("FAIL accept_body got=%h exp=%h", body_o, BODY_A); end
    n_cmp++; if (maj_o !== 64'd16 || addr_o !== 64'd16) begin
      n_fail++; $display("FAIL accept_ids got maj=%0d addr=%0d exp 16/16", maj_o, addr_o);
    end
    n_cmp++; if (prim_o !== 6'd16 || min_o !== 7'd0 || is64_o !== 1'b1 || pid_o !== 20'hABCDE || tid_o !== 16'h1234) begin
      n_fail++; $display("FAIL accept_passthru got prim=%0d min=%0d is64=%b pid=%h tid=%h", prim_o, min_o, is64_o, pid_o, tid_o);
    end
    tick();
    n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL accept_drop got=%b exp=0", v_o); end
  endtask

  task automatic test_opcode_sweep();
    for (int op = 0; op <= 62; op++) begin
      drive(1'b1, 26'd2, 6'(op), {6'(op), INSTR_B[25:0]}, 64'(op), 64'(op + 100));
      tick();
      n_cmp++; if (v_o !== (op == 16)) begin n_fail++; $display("FAIL sweep_op%0d got=%b exp=%b", op, v_o, (op == 16)); end
    end
    drive(1'b0, 26'd2, 6'd0, 32'd0, 64'd0, 64'd0);
    tick();
  endtask

  task automatic test_aa_lk();
    drive(1'b1, 26'd2, 6'd16, INSTR_B, 64'h1000, 64'd1);
    tick();
    n_cmp++; if (v_o !== 1'b1 || body_o !== BODY_B) begin n_fail++; $display("FAIL aa1_lk0 got v=%b body=%h exp 1/%h", v_o, body_o, BODY_B); end
    n_cmp++; if (body_o[3:2] !== 2'b10) begin n_fail++; $display("FAIL aa1_lk0_bits got=%b exp=10", body_o[3:2]); end
    drive(1'b1, 26'd2, 6'd16, INSTR_C, 64'h1004, 64'd2);
    tick();
    n_cmp++; if (v_o !== 1'b1 || body_o !== BODY_C) begin n_fail++; $display("FAIL aa0_lk1 got v=%b body=%h exp 1/%h", v_o, body_o, BODY_C); end
    n_cmp++; if (addr_o !== 64'h1004 || maj_o !== 64'd2) begin n_fail++; $display("FAIL back_to_back_ids got addr=%h maj=%0d exp 1004/2", addr_o, maj_o); end
    drive(1'b0, 26'd2, 6'd16, INSTR_C, 64'h1004, 64'd2);
    tick();
  endtask

  task automatic test_format();
    drive(1'b1, 26'd1, 6'd16, INSTR_A, 64'h20, 64'd3);
    tick();
    n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL wrong_format got=%b exp=0", v_o); end
    drive(1'b0, 26'd2, 6'd16, INSTR_A, 64'h24, 64'd4);
    tick();
    n_cmp++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL not_enabled got=%b exp=0", v_o); end
    drive(1'b1, 26'd3, 6'd16, INSTR_A, 64'h28, 64'd5);
    tick();
    n_cmp++; if (v_o !== 1'b1 || addr_o !== 64'h28) begin n_fail++; $display("FAIL multi_format got v=%b addr=%h exp 1/28", v_o, addr_o); end
    drive(1'b0, 26'd0, 6'd0, 32'd0, 64'd0, 64'd0);
    tick();
  endtask

  task automatic test_stall();
    drive(1'b1, 26'd2, 6'd16, INSTR_A, 64'h40, 64'd7);
    tick();
    stall = 1'b1;
    drive(1'b1, 26'd2, 6'd16, INSTR_B, 64'h80, 64'd8);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (v_o !== 1'b1 || body_o !== BODY_A || addr_o !== 64'h40 || maj_o !== 64'd7) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b body=%h addr=%h maj=%0d exp 1/%h/40/7", c, v_o, body_o, addr_o, maj_o, BODY_A);
      end
    end
    stall = 1'b0;
    drive(1'b0, 26'd2, 6'd16, INSTR_B, 64'h80, 64'd8);
    tick();
    n_cmp++; if (v_o !== 1'b0 || body_o !== BODY_A) begin n_fail++; $display("FAIL stall_release got v=%b body=%h exp 0/%h", v_o, body_o, BODY_A); end
  endtask

  task automatic test_reset_while_valid();
    drive(1'b1, 26'd2, 6'd16, INSTR_A, 64'h99, 64'd9);
    tick();
    n_cmp++; if (v_o !== 1'b1) begin n_fail++; $display("FAIL prereset_valid got=%b exp=1", v_o); end
    rst_n = 1'b0;
    stall = 1'b1;
    drive(1'b1, 26'd2, 6'd16, INSTR_B, 64'hAA, 64'd10);
    tick();
    n_cmp++; if (v_o !== 1'b0 || body_o !== 28'd0 || addr_o !== 64'd0 || maj_o !== 64'd0 || fu_o !== 3'd0 || opc_o !== 12'd0) begin
      n_fail++; $display("FAIL reset_valid got v=%b body=%h addr=%h maj=%0d fu=%0d opc=%h exp all zero", v_o, body_o, addr_o, maj_o, fu_o, opc_o);
    end
    rst_n = 1'b1;
    stall = 1'b0;
    drive(1'b0, 26'd0, 6'd0, 32'd0, 64'd0, 64'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; is64 = 1'b0; pid = '0; tid = '0;
    drive(1'b0, 26'd0, 6'd0, 32'd0, 64'd0, 64'd0);
    test_reset();
    test_accept();
    test_opcode_sweep();
    test_aa_lk();
    test_format();
    test_stall();
    test_reset_while_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
